// File: rtl/axilite_write_channel.sv
// axilite_write_channel: AXI4-Lite slave write path (AW/W in, B out) applying byte strobes to a flat register vector (regs, reg_written out)
module axilite_write_channel #(
  parameter int DATA_SIZE   = 32*4,
  parameter int ADDR_SIZE   = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int RESP_OKAY   = 0,
  parameter int RESP_EXOKAY = 1,
  parameter int RESP_SLVERR = 2,
  parameter int RESP_DECERR = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ADDR_SIZE-1:0]             awaddr,
  input  logic                             awvalid,
  output logic                             awready,
  input  logic [DATA_WIDTH-1:0]            wdata,
  input  logic [DATA_WIDTH/8-1:0]          wstrb,
  input  logic                             wvalid,
  output logic                             wready,
  output logic [1:0]                       bresp,
  output logic                             bvalid,
  input  logic                             bready,
  output logic [DATA_SIZE-1:0]             regs,
  output logic [DATA_SIZE/DATA_WIDTH-1:0]  reg_written
);
  localparam int NUM_REGS = DATA_SIZE / DATA_WIDTH;
  localparam int LANES = DATA_WIDTH / 8;
  localparam int SHIFT = $clog2(LANES);
  localparam logic [7:0] RESP_MAP = {2'(RESP_DECERR), 2'(RESP_SLVERR), 2'(RESP_EXOKAY), 2'(RESP_OKAY)};
  typedef enum logic [1:0] {COLLECT, COMMIT, RESP} state_t;
  state_t state, state_next;
  logic aw_held, w_held, aw_hs, w_hs, in_range;
  logic [ADDR_SIZE-1:0] addr_q, idx;
  logic [DATA_WIDTH-1:0] data_q;
  logic [LANES-1:0] strb_q;
  logic [NUM_REGS-1:0] hit;
  logic [DATA_SIZE-1:0] regs_next;
  assign aw_hs = awready && awvalid;
  assign w_hs = wready && wvalid;
  assign idx = addr_q >> SHIFT;
  assign in_range = idx < ADDR_SIZE'(NUM_REGS);
  always_comb begin
    state_next = state == COMMIT ? RESP :
                 state == RESP ? (bready ? COLLECT : RESP) :
                 ((aw_held || aw_hs) && (w_held || w_hs)) ? COMMIT : COLLECT;
  end
  always_comb begin
    hit = '0;
    regs_next = regs;
    for (int r = 0; r < NUM_REGS; r++) begin
      hit[r] = in_range && idx == ADDR_SIZE'(r);
      for (int b = 0; b < LANES; b++)
        regs_next[r*DATA_WIDTH+b*8 +: 8] = (hit[r] && strb_q[b]) ? data_q[b*8 +: 8] : regs[r*DATA_WIDTH+b*8 +: 8];
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= COLLECT;
    else state <= state_next;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      awready <= 1'b0;
      wready <= 1'b0;
      bvalid <= 1'b0;
      bresp <= RESP_MAP[1:0];
      regs <= '0;
      reg_written <= '0;
      aw_held <= 1'b0;
      w_held <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      strb_q <= '0;
    end else begin
      reg_written <= '0;
      case (state)
        COLLECT: begin
          if (aw_hs) begin
            addr_q <= awaddr;
            aw_held <= 1'b1;
          end
          if (w_hs) begin
            data_q <= wdata;
            strb_q <= wstrb;
            w_held <= 1'b1;
          end
          awready <= !(aw_held || aw_hs);
          wready <= !(w_held || w_hs);
        end
        COMMIT: begin
          regs <= regs_next;
          reg_written <= hit;
          bresp <= in_range ? RESP_MAP[1:0] : RESP_MAP[5:4];
          bvalid <= 1'b1;
        end
        RESP: begin
          if (bready) begin
            bvalid <= 1'b0;
            aw_held <= 1'b0;
            w_held <= 1'b0;
            awready <= 1'b1;
            wready <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_axilite_write_channel.sv
// tb_axilite_write_channel: randomized self-checking bench against a register-array reference model
module tb_axilite_write_channel;
  logic clk = 0, rst = 0;
  logic [31:0] awaddr = 0, wdata = 0;
  logic [3:0] wstrb = 0, reg_written;
  logic awvalid = 0, wvalid = 0, bready = 0;
  logic awready, wready, bvalid;
  logic [1:0] bresp;
  logic [127:0] regs;
  int total = 0, bad = 0;
  logic [31:0] m [4];
  logic [1:0] o_resp;
  logic [3:0] o_pulse;
  int o_pcnt, o_lat;
  bit o_to, o_rdy, o_stable, o_bafter;
  axilite_write_channel dut (
    .clk(clk), .rst(rst), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready), .regs(regs), .reg_written(reg_written)
  );
  always #5 clk = ~clk;
  function automatic logic [127:0] flat();
    return {m[3], m[2], m[1], m[0]};
  endfunction
  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int i = int'(a >> 2);
    if (i < 4)
      for (int b = 0; b < 4; b++)
        if (s[b]) m[i][b*8 +: 8] = d[b*8 +: 8];
  endtask
  task automatic acc();
    o_pulse |= reg_written;
    if (reg_written != 0) o_pcnt++;
  endtask
  task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int aw_dly, input int w_dly, input int b_dly);
    bit aw_done = 0, w_done = 0, aw_f, w_f;
    int cyc = 0;
    o_pulse = 0; o_pcnt = 0; o_to = 0; o_rdy = 1; o_stable = 1; o_lat = -1; o_resp = 2'bxx; o_bafter = 1;
    awaddr = a; wdata = d; wstrb = s;
    while (!(aw_done && w_done) && !o_to) begin
      awvalid = !aw_done && cyc >= aw_dly;
      wvalid = !w_done && cyc >= w_dly;
      if (aw_done && awready !== 1'b0) o_rdy = 0;
      if (w_done && wready !== 1'b0) o_rdy = 0;
      aw_f = awvalid && awready;
      w_f = wvalid && wready;
      acc();
      @(posedge clk); #1;
      if (aw_f) aw_done = 1;
      if (w_f) w_done = 1;
      if (++cyc > 50) o_to = 1;
    end
    awvalid = 0; wvalid = 0;
    cyc = 0;
    while (bvalid !== 1'b1 && !o_to) begin
      acc();
      @(posedge clk); #1;
      if (++cyc > 10) o_to = 1;
    end
    if (o_to) return;
    o_lat = cyc;
    o_resp = bresp;
    for (int i = 0; i < b_dly; i++) begin
      acc();
      if (bvalid !== 1'b1 || bresp !== o_resp || awready !== 1'b0 || wready !== 1'b0) o_stable = 0;
      @(posedge clk); #1;
    end
    acc();
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
    o_bafter = bvalid;
    acc();
  endtask
  task automatic test_reset();
    for (int i = 0; i < 4; i++) m[i] = 0;
    @(posedge clk); #1;
    total++;
    if (awready !== 0 || wready !== 0 || bvalid !== 0 || regs !== 0 || reg_written !== 0 || bresp !== 0) begin
      bad++; $display("FAIL reset_hold got aw=%b w=%b bv=%b regs=%h rw=%b br=%0d exp all 0", awready, wready, bvalid, regs, reg_written, bresp);
    end
    rst = 1;
    @(posedge clk); #1;
    total++;
    if (awready !== 1 || wready !== 1 || bvalid !== 0 || regs !== 0) begin
      bad++; $display("FAIL reset_release got aw=%b w=%b bv=%b regs=%h exp aw=1 w=1 bv=0 regs=0", awready, wready, bvalid, regs);
    end
  endtask
  task automatic test_same_cycle();
    xfer(32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    model_write(32'h4, 32'hDEADBEEF, 4'hF);
    total++;
    if (o_to || regs[63:32] !== 32'hDEADBEEF || regs !== flat()) begin
      bad++; $display("FAIL same_cycle_regs got=%h exp=%h to=%0d", regs, flat(), o_to);
    end
    total++;
    if (o_pulse !== 4'b0010 || o_pcnt !== 1 || o_resp !== 0 || o_lat !== 1) begin
      bad++; $display("FAIL same_cycle_resp got pulse=%b cnt=%0d resp=%0d lat=%0d exp 0010/1/0/1", o_pulse, o_pcnt, o_resp, o_lat);
    end
  endtask
  task automatic test_w_first();
    xfer(32'h8, 32'h12345678, 4'hF, 3, 0, 0);
    model_write(32'h8, 32'h12345678, 4'hF);
    total++;
    if (o_rdy !== 1 || o_lat !== 1) begin
      bad++; $display("FAIL w_first_timing got rdy_ok=%0d lat=%0d exp 1/1", o_rdy, o_lat);
    end
    total++;
    if (regs[95:64] !== 32'h12345678 || regs !== flat() || o_pulse !== 4'b0100) begin
      bad++; $display("FAIL w_first_regs got=%h pulse=%b exp=%h pulse=0100", regs, o_pulse, flat());
    end
  endtask
  task automatic test_strobes();
    xfer(32'h4, 32'h000000AA, 4'b0001, 1, 2, 1);
    model_write(32'h4, 32'h000000AA, 4'b0001);
    total++;
    if (regs[63:32] !== 32'hDEADBEAA || regs !== flat()) begin
      bad++; $display("FAIL strobe_partial got=%h exp=%h", regs, flat());
    end
    xfer(32'h7, 32'h11223344, 4'b0000, 0, 0, 0);
    total++;
    if (regs !== flat() || o_pulse !== 4'b0010 || o_resp !== 0) begin
      bad++; $display("FAIL strobe_zero got regs=%h pulse=%b resp=%0d exp regs=%h pulse=0010 resp=0", regs, o_pulse, o_resp, flat());
    end
  endtask
  task automatic test_out_of_range();
    xfer(32'h10, 32'hCAFEF00D, 4'hF, 0, 1, 2);
    total++;
    if (o_resp !== 2 || regs !== flat() || o_pulse !== 0 || o_stable !== 1) begin
      bad++; $display("FAIL out_of_range got resp=%0d regs=%h pulse=%b stable=%0d exp resp=2 regs=%h pulse=0 stable=1", o_resp, regs, o_pulse, o_stable, flat());
    end
  endtask
  task automatic test_backpressure();
    bit ok = 1;
    awaddr = 32'h0; wdata = 32'hA5A5_0F0F; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    @(posedge clk); #1;
    wvalid = 0; awaddr = 32'hC; bready = 0;
    @(posedge clk); #1;
    model_write(32'h0, 32'hA5A5_0F0F, 4'hF);
    for (int i = 0; i < 5; i++) begin
      if (bvalid !== 1 || bresp !== 0 || awready !== 0 || wready !== 0) ok = 0;
      @(posedge clk); #1;
    end
    total++;
    if (!ok || regs !== flat()) begin
      bad++; $display("FAIL backpressure_hold got ok=%0d regs=%h exp ok=1 regs=%h", ok, regs, flat());
    end
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
    total++;
    if (bvalid !== 0 || awready !== 1 || wready !== 1) begin
      bad++; $display("FAIL backpressure_release got bv=%b aw=%b w=%b exp 0/1/1", bvalid, awready, wready);
    end
    @(posedge clk); #1;
    awvalid = 0;
    total++;
    if (awready !== 0 || wready !== 1) begin
      bad++; $display("FAIL backpressure_new_aw got aw=%b w=%b exp 0/1", awready, wready);
    end
    wdata = 32'h0BADC0DE; wstrb = 4'b1100; wvalid = 1;
    @(posedge clk); #1;
    wvalid = 0;
    @(posedge clk); #1;
    model_write(32'hC, 32'h0BADC0DE, 4'b1100);
    total++;
    if (bvalid !== 1 || bresp !== 0 || regs !== flat() || reg_written !== 4'b1000) begin
      bad++; $display("FAIL backpressure_second got bv=%b br=%0d regs=%h rw=%b exp 1/0/%h/1000", bvalid, bresp, regs, reg_written, flat());
    end
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
  endtask
  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      logic [31:0] a, d;
      logic [3:0] s;
      int idx;
      idx = int'($urandom_range(0, 5));
      a = (32'(idx) << 2) | 32'($urandom_range(0, 3));
      d = $urandom;
      s = 4'($urandom);
      xfer(a, d, s, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      model_write(a, d, s);
      total++;
      if (o_to || regs !== flat() || o_lat !== 1 || o_bafter !== 0) begin
        bad++; $display("FAIL random_regs n=%0d got=%h lat=%0d to=%0d bafter=%0d exp=%h lat=1", n, regs, o_lat, o_to, o_bafter, flat());
      end
      total++;
      if (o_resp !== (idx < 4 ? 2'd0 : 2'd2) || o_pulse !== (idx < 4 ? 4'(1 << idx) : 4'd0) ||
          o_pcnt !== (idx < 4 ? 1 : 0) || o_stable !== 1 || o_rdy !== 1) begin
        bad++; $display("FAIL random_resp n=%0d got resp=%0d pulse=%b cnt=%0d stable=%0d rdy=%0d idx=%0d", n, o_resp, o_pulse, o_pcnt, o_stable, o_rdy, idx);
      end
    end
  endtask
  task automatic test_reset_commit();
    bit ok = 1;
    awaddr = 32'h4; wdata = 32'h55AA55AA; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    #2 rst = 0;
    #1;
    for (int i = 0; i < 4; i++) m[i] = 0;
    total++;
    if (bvalid !== 0 || regs !== 0 || awready !== 0 || reg_written !== 0) begin
      bad++; $display("FAIL reset_commit_now got bv=%b regs=%h aw=%b rw=%b exp all 0", bvalid, regs, awready, reg_written);
    end
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      if (bvalid !== 0 || regs !== 0 || awready !== 1 || wready !== 1) ok = 0;
      @(posedge clk); #1;
    end
    total++;
    if (!ok) begin
      bad++; $display("FAIL reset_commit_after got bv=%b regs=%h aw=%b w=%b exp 0/0/1/1", bvalid, regs, awready, wready);
    end
    xfer(32'h0, 32'hFEEDFACE, 4'b0110, 0, 0, 0);
    model_write(32'h0, 32'hFEEDFACE, 4'b0110);
    total++;
    if (regs !== flat() || o_pulse !== 4'b0001 || o_resp !== 0) begin
      bad++; $display("FAIL reset_commit_recover got regs=%h pulse=%b resp=%0d exp %h/0001/0", regs, o_pulse, o_resp, flat());
    end
  endtask
  initial begin
    test_reset();
    test_same_cycle();
    test_w_first();
    test_strobes();
    test_out_of_range();
    test_backpressure();
    test_random();
    test_reset_commit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
